pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the fetch PC of the 5-stage MIPS pipeline and sequences it every clk: sequential
//  fetch, branch/jump/jr redirects from the D-stage decision, hazard-unit stalls, exception
//  entry and eret return. Sits between controller/hazard unit (D) and IM (F); drives pc_f.
// PARAMETERS
//  RESET_PC   32'h0000_3000  fetch address after reset
//  EXC_VECTOR 32'h0000_4180  exception/interrupt handler entry
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high
//  stall      in   1   hazard unit: freeze F and D (PC holds)
//  pc_sel     in   3   D-stage next-PC select: 0 seq, 1 branch, 2 j/jal, 3 jr
//  br_taken   in   1   D-stage comparator result; qualifies pc_sel==1
//  ir_d       in   32  D-stage instruction (imm16 / instr_index)
//  pc4_d      in   32  D-stage PC+4
//  rsd_out    in   32  forwarded rs value (jr target)
//  exc_req    in   1   exception/interrupt taken this cycle (from CP0)
//  eret       in   1   eret in D this cycle
//  epc        in   32  CP0 EPC (eret target)
//  pc_f       out  32  current fetch address
//  pc4_f      out  32  pc_f + 4
//  bd_f       out  1   instruction in F is a branch/jump delay slot
//  flush_f    out  1   kill the instruction currently in F (eret/exception redirect)
//  state_o    out  2   FSM state, debug/verification only
// BEHAVIOUR
//  Reset (reset=1 at posedge): pc_f<=RESET_PC, state<=BOOT, bd_f=0, flush_f=0.
//  FSM states: BOOT(0), RUN(1), HOLD(2), EXC(3).
//   BOOT: one cycle; pc_f held at RESET_PC, D inputs ignored (D holds a bubble) -> RUN.
//   RUN:  stall=1 -> HOLD, pc_f unchanged. Else pc_f<=target (below).
//   HOLD: pc_f unchanged; pc_sel/eret ignored; stall=0 -> RUN (D decision re-evaluated
//         next cycle with fresh forwarded operands).
//   EXC:  entered on exc_req; pc_f<=EXC_VECTOR at that edge; next cycle -> RUN.
//  Target priority (highest first), evaluated in RUN with stall=0:
//   1 exc_req          -> EXC_VECTOR, flush_f=1   (also overrides stall and HOLD/BOOT)
//   2 eret             -> epc, flush_f=1 (no delay slot executes)
//   3 pc_sel==3        -> rsd_out
//   4 pc_sel==2        -> {pc_f'[31:28], ir_d[25:0], 2'b00}, pc_f' = pc4_d-4
//   5 pc_sel==1 & br_taken -> pc4_d + sign_ext(ir_d[15:0])<<2 (32-bit wrap)
//   6 otherwise        -> pc_f + 4 (wraps 32'hFFFF_FFFC -> 0)
//  pc_sel==1 with br_taken=0 is sequential; pc_sel 4..7 treated as 0.
//  bd_f (combinational): state==RUN & pc_sel!=0 & !eret & !exc_req; also valid in HOLD
//   (F holds the slot while the branch waits). 0 in BOOT/EXC.
//  flush_f combinational, same cycle as the redirect decision; 0 otherwise.
//  exc_req with stall=1: exception wins, PC redirects, state -> EXC.
//  reset mid-operation (any state, any input): reset wins; outputs as above next cycle.
//  No alignment checking here; misaligned jr targets are fetched and trapped downstream.
// STRUCTURE
//  Shared header/package: PC_SEL_SEQ/BRANCH/JUMP/JR encodings, FSM state codes,
//   RESET_PC and EXC_VECTOR defaults (shared with CP0 and IM address decode).
//  Sub-module npc_calc: pure combinational target mux for priorities 3..6.
//  This module: FSM, PC register, exception/eret override, bd_f/flush_f.
// TESTING
//  1 reset 2 cycles, release -> pc_f 0x3000 (BOOT), then 0x3004, 0x3008; bd_f=0.
//  2 RUN pc_f=0x3010, pc4_d=0x300C, ir_d=beq imm16=0xFFFE, br_taken=1 -> pc_f 0x3004; bd_f=1
//    same cycle; repeat with br_taken=0 -> 0x3014.
//  3 pc_sel=2, pc4_d=0x0000_3020, ir_d[25:0]=0x0000C40 -> pc_f 0x0000_3100; pc_sel=3,
//    rsd_out=0x3344 -> 0x3344.
//  4 jr in D with stall=1 for 3 cycles, rsd_out changing -> pc_f frozen, state HOLD, bd_f=1;
//    stall drops with rsd_out=0x3500 -> pc_f 0x3500 (value after stall only).
//  5 exc_req=1 coincident with stall=1 and pc_sel=1 -> pc_f 0x4180, flush_f=1, state EXC then
//    RUN; eret with epc=0x3024 -> pc_f 0x3024, flush_f=1, bd_f=0.
//  6 pc_f=0xFFFF_FFFC sequential -> 0x0000_0000; reset asserted while in HOLD/EXC -> 0x3000.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and defaults for the fetch PC sequencer. The PC-select codes and the
// reset/exception addresses are also used by CP0 and the IM address decode.
package pc_sequencer_pkg;

  // D-stage next-PC select encodings
  localparam logic [2:0] PC_SEL_SEQ    = 3'd0;
  localparam logic [2:0] PC_SEL_BRANCH = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
  localparam logic [2:0] PC_SEL_JR     = 3'd3;

  // Default fetch addresses
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  // Sequencer FSM states; codes are visible on state_o
  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StExc  = 2'd3
  } state_e;

  // Select codes 4..7 are undefined and behave as sequential fetch
  function automatic logic [2:0] norm_pc_sel(input logic [2:0] pc_sel);
    return pc_sel[2] ? PC_SEL_SEQ : pc_sel;
  endfunction

  // Branch target: pc4 + (sign-extended imm16 << 2), wrapping at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm16);
    logic [31:0] offset;
    offset = {{14{imm16[15]}}, imm16, 2'b00};
    return pc4 + offset;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the D-stage controller/hazard unit/CP0 (master) and the PC sequencer
// (slave). The master drives the redirect decision; the slave drives the fetch address.
interface pc_sequencer_if;

  logic        stall;
  logic [2:0]  pc_sel;
  logic        br_taken;
  logic [31:0] ir_d;
  logic [31:0] pc4_d;
  logic [31:0] rsd_out;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;

  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic        bd_f;
  logic        flush_f;
  logic [1:0]  state_o;

  modport master (
    output stall, pc_sel, br_taken, ir_d, pc4_d, rsd_out, exc_req, eret, epc,
    input  pc_f, pc4_f, bd_f, flush_f, state_o
  );

  modport slave (
    input  stall, pc_sel, br_taken, ir_d, pc4_d, rsd_out, exc_req, eret, epc,
    output pc_f, pc4_f, bd_f, flush_f, state_o
  );

endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Combinational next-PC mux for the normal (non-exception, non-eret) redirect sources:
// jr, j/jal, taken branch, and sequential fetch.
module pc_sequencer_npc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [2:0]  pc_sel_i,
  input  logic        br_taken_i,
  input  logic [31:0] ir_d_i,
  input  logic [31:0] pc4_d_i,
  input  logic [31:0] rsd_i,
  input  logic [31:0] pc_f_i,
  output logic [31:0] npc_o
);

  logic [2:0]  sel;
  logic [31:0] pc_d;
  logic        unused_bits;

  assign sel  = norm_pc_sel(pc_sel_i);
  // The jump region comes from the jump's own PC, not its delay slot
  assign pc_d = pc4_d_i - 32'd4;

  assign unused_bits = ^{ir_d_i[31:26], pc_d[27:0]};

  // Select the redirect target for the instruction in D
  always_comb begin
    npc_o = pc_f_i + 32'd4;
    unique case (sel)
      PC_SEL_JR:     npc_o = rsd_i;
      PC_SEL_JUMP:   npc_o = {pc_d[31:28], ir_d_i[25:0], 2'b00};
      PC_SEL_BRANCH: if (br_taken_i) npc_o = branch_target(pc4_d_i, ir_d_i[15:0]);
      default:       npc_o = pc_f_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the 5-stage pipeline: PC register, boot/run/hold/exception FSM,
// exception and eret overrides, and the delay-slot / F-flush indications.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  pc_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc;
  logic        flush;
  logic        slot_cmd;

  pc_sequencer_npc_calc u_npc_calc (
    .pc_sel_i   (bus.pc_sel),
    .br_taken_i (bus.br_taken),
    .ir_d_i     (bus.ir_d),
    .pc4_d_i    (bus.pc4_d),
    .rsd_i      (bus.rsd_out),
    .pc_f_i     (pc_q),
    .npc_o      (npc)
  );

  // Next state and next PC; an exception request overrides every state and the stall
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    if (bus.exc_req) begin
      state_d = StExc;
      pc_d    = EXC_VECTOR;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        // D holds a bubble, so the first fetch simply advances sequentially
        StBoot: begin
          state_d = StRun;
          pc_d    = pc_q + 32'd4;
        end
        StRun: begin
          if (bus.stall) begin
            state_d = StHold;
          end else if (bus.eret) begin
            pc_d  = bus.epc;
            flush = 1'b1;
          end else begin
            pc_d = npc;
          end
        end
        // Leave HOLD without redirecting so D re-decides with fresh forwarded operands
        StHold: begin
          if (!bus.stall) state_d = StRun;
        end
        // D holds the killed instruction; advance past the handler entry
        StExc: begin
          state_d = StRun;
          pc_d    = pc_q + 32'd4;
        end
        default: state_d = StBoot;
      endcase
    end
  end

  // PC and FSM state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Delay-slot flag: F holds the slot of a branch/jump in D, including while it waits in HOLD
  always_comb begin
    slot_cmd    = (norm_pc_sel(bus.pc_sel) != PC_SEL_SEQ) && !bus.eret && !bus.exc_req;
    bus.bd_f    = slot_cmd && ((state_q == StRun) || (state_q == StHold));
    bus.flush_f = flush && !reset;
    bus.pc_f    = pc_q;
    bus.pc4_f   = pc_q + 32'd4;
    bus.state_o = state_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. The stimulus process drives the D-stage inputs just after
// each rising edge and queues the hand-computed outputs expected for that cycle; a separate
// monitor pops one expectation per falling edge and compares it with the DUT.
module tb_pc_sequencer;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        bd;
    logic        fl;
    logic [1:0]  st;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
    end
  endtask

  // Monitor: compare whatever expectation is pending for this cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "pc_f",    bus.pc_f,          e.pc);
      chk(e.name, "pc4_f",   bus.pc4_f,         e.pc + 32'd4);
      chk(e.name, "bd_f",    {31'd0, bus.bd_f},    {31'd0, e.bd});
      chk(e.name, "flush_f", {31'd0, bus.flush_f}, {31'd0, e.fl});
      chk(e.name, "state_o", {30'd0, bus.state_o}, {30'd0, e.st});
    end
  end

  task automatic drive(input logic s, input logic [2:0] sel, input logic br,
                       input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] rsd,
                       input logic exc, input logic er, input logic [31:0] ep);
    bus.stall    = s;
    bus.pc_sel   = sel;
    bus.br_taken = br;
    bus.ir_d     = ir;
    bus.pc4_d    = pc4;
    bus.rsd_out  = rsd;
    bus.exc_req  = exc;
    bus.eret     = er;
    bus.epc      = ep;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic bd,
                            input logic fl, input logic [1:0] st);
    exp_t e;
    e.name = name;
    e.pc   = pc;
    e.bd   = bd;
    e.fl   = fl;
    e.st   = st;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] BEQ_M2 = 32'h1000_FFFE;  // beq, imm16 = -2
  localparam logic [31:0] J_C40  = 32'h0800_0C40;  // j, instr_index = 0xC40

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // 1: boot and sequential fetch
    expect_out("boot", 32'h3000, 1'b0, 1'b0, 2'd0);  tick();
    expect_out("seq1", 32'h3004, 1'b0, 1'b0, 2'd1);  tick();
    expect_out("seq2", 32'h3008, 1'b0, 1'b0, 2'd1);  tick();
    expect_out("seq3", 32'h300C, 1'b0, 1'b0, 2'd1);  tick();

    // 2: taken beq back by two words, then jr back to 0x3010 and not-taken beq
    drive(1'b0, 3'd1, 1'b1, BEQ_M2, 32'h300C, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("beq_t", 32'h3010, 1'b1, 1'b0, 2'd1);  tick();
    drive(1'b0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h3010, 1'b0, 1'b0, 32'h0);
    expect_out("jr_back", 32'h3004, 1'b1, 1'b0, 2'd1);  tick();
    drive(1'b0, 3'd1, 1'b0, BEQ_M2, 32'h300C, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("beq_nt", 32'h3010, 1'b1, 1'b0, 2'd1);  tick();

    // 3: j and jr
    drive(1'b0, 3'd2, 1'b0, J_C40, 32'h3020, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("j", 32'h3014, 1'b1, 1'b0, 2'd1);  tick();
    drive(1'b0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h3344, 1'b0, 1'b0, 32'h0);
    expect_out("jr", 32'h3100, 1'b1, 1'b0, 2'd1);  tick();

    // 4: jr stalled for three cycles with a moving operand
    drive(1'b1, 3'd3, 1'b0, 32'h0, 32'h0, 32'h1111, 1'b0, 1'b0, 32'h0);
    expect_out("stall0", 32'h3344, 1'b1, 1'b0, 2'd1);  tick();
    drive(1'b1, 3'd3, 1'b0, 32'h0, 32'h0, 32'h2222, 1'b0, 1'b0, 32'h0);
    expect_out("hold1", 32'h3344, 1'b1, 1'b0, 2'd2);  tick();
    drive(1'b1, 3'd3, 1'b0, 32'h0, 32'h0, 32'h3333, 1'b0, 1'b0, 32'h0);
    expect_out("hold2", 32'h3344, 1'b1, 1'b0, 2'd2);  tick();
    drive(1'b0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h3500, 1'b0, 1'b0, 32'h0);
    expect_out("hold_rel", 32'h3344, 1'b1, 1'b0, 2'd2);  tick();
    expect_out("jr_fresh", 32'h3344, 1'b1, 1'b0, 2'd1);  tick();

    // 5: exception beats stall and a taken branch; then eret
    drive(1'b1, 3'd1, 1'b1, 32'h1000_0004, 32'h3504, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("exc", 32'h3500, 1'b0, 1'b1, 2'd1);  tick();
    idle();
    expect_out("exc_st", 32'h4180, 1'b0, 1'b0, 2'd3);  tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3024);
    expect_out("eret", 32'h4184, 1'b0, 1'b1, 2'd1);  tick();

    // 6: wrap at the top of the address space, reset from HOLD and from EXC
    drive(1'b0, 3'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    expect_out("eret_tgt", 32'h3024, 1'b1, 1'b0, 2'd1);  tick();
    idle();
    expect_out("top", 32'hFFFF_FFFC, 1'b0, 1'b0, 2'd1);  tick();
    drive(1'b1, 3'd3, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0);
    expect_out("wrap", 32'h0, 1'b1, 1'b0, 2'd1);  tick();
    reset = 1'b1;
    expect_out("hold_rst", 32'h0, 1'b1, 1'b0, 2'd2);  tick();
    reset = 1'b0;
    idle();
    expect_out("rst_hold", 32'h3000, 1'b0, 1'b0, 2'd0);  tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("exc2", 32'h3004, 1'b0, 1'b1, 2'd1);  tick();
    idle();
    reset = 1'b1;
    expect_out("exc_st2", 32'h4180, 1'b0, 1'b0, 2'd3);  tick();
    reset = 1'b0;
    expect_out("rst_exc", 32'h3000, 1'b0, 1'b0, 2'd0);  tick();
    expect_out("post", 32'h3004, 1'b0, 1'b0, 2'd1);  tick();

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
